data_memory_ctrl: RTL and testbench

//  Parametrised byte-addressed, big-endian data memory for the multi-cycle CPU MEM/WB stages.

---
 rtl/dmem_pkg.sv | 36 +++
 rtl/data_memory_ctrl_byte_lane_ram.sv | 35 +++
 rtl/data_memory_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings, FSM states and lane helpers for the data memory controller.
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Byte lanes touched by an access. Bit i is lane i, and lane 0 holds the
    // byte at word offset 0, which is the most significant byte (big-endian).
    function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: lane_sel = 4'b0001 << off;
            SIZE_HALF: lane_sel = off[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: lane_sel = 4'b1111;
            default:   lane_sel = 4'b0000;
        endcase
    endfunction

    // Number of bytes moved by an access; the reserved size moves nothing.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_bytes = 3'd1;
            SIZE_HALF: size_bytes = 3'd2;
            SIZE_WORD: size_bytes = 3'd4;
            default:   size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_ctrl_byte_lane_ram.sv
// Four byte-wide RAM banks, one per big-endian lane, with per-lane write
// enables and a registered read port that only updates when re_i is high.
module byte_lane_ram #(
    parameter int ROWS  = 64,
    parameter int ROW_W = 6
) (
    input  logic             clk,
    input  logic [ROW_W-1:0] row_i,
    input  logic [3:0]       we_i,
    input  logic [31:0]      wdata_i,
    input  logic             re_i,
    output logic [31:0]      rdata_o
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] bank [ROWS];
            logic [7:0] rd_q;

            // Lane write and registered read; the read register holds between reads.
            always_ff @(posedge clk) begin
                if (we_i[gi]) begin
                    bank[row_i] <= wdata_i[31-8*gi -: 8];
                end
                if (re_i) begin
                    rd_q <= bank[row_i];
                end
            end

            assign rdata_o[31-8*gi -: 8] = rd_q;
        end
    endgenerate

endmodule

// File: rtl/data_memory_ctrl.sv
// Big-endian byte-addressed data memory with valid/ready requests, optional
// wait states, size/alignment/range checking and a registered write-back mux.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DEPTH_BYTES = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    input  logic [31:0]       alu_result,
    input  logic              mem_to_reg,
    output logic [31:0]       wb_data
);

    localparam int ROWS  = DEPTH_BYTES / 4;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SUM_W = ADDR_W + 3;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    // Request captured at accept, used when the access finishes from WAIT
    logic              we_q;
    logic              signed_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    // Response-side state, only changed on the edge that enters RESP
    logic        rsp_err_q;
    logic        rsp_zero_q;
    logic        rsp_signed_q;
    logic [1:0]  rsp_size_q;
    logic [1:0]  rsp_off_q;
    logic [31:0] wb_q;

    // The access that completes on the next edge (live inputs when leaving IDLE)
    logic              cur_we;
    logic              cur_signed;
    logic [1:0]        cur_size;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wdata;

    logic             cur_err;
    logic             enter_resp;
    logic [SUM_W-1:0] end_addr;
    logic [3:0]       lane_we;
    logic [31:0]      lane_wdata;
    logic             ram_re;
    logic [31:0]      ram_rdata;
    logic [7:0]       sel_byte;
    logic [15:0]      sel_half;
    logic [31:0]      ext_data;

    // State register and wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: accept in IDLE, optional WAIT countdown, one RESP cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the request at accept so the requester may move on
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= SIZE_BYTE;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
        end else if (state_q == IDLE && req_valid) begin
            we_q     <= req_we;
            signed_q <= req_signed;
            size_q   <= req_size;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
        end
    end

    // Select live inputs in IDLE (zero-wait case) or the captured request otherwise
    always_comb begin
        if (state_q == IDLE) begin
            cur_we     = req_we;
            cur_signed = req_signed;
            cur_size   = req_size;
            cur_addr   = req_addr;
            cur_wdata  = req_wdata;
        end else begin
            cur_we     = we_q;
            cur_signed = signed_q;
            cur_size   = size_q;
            cur_addr   = addr_q;
            cur_wdata  = wdata_q;
        end
    end

    // Alignment, reserved-size and range checks on the completing access
    always_comb begin
        end_addr = SUM_W'(cur_addr) + SUM_W'(size_bytes(cur_size));
        cur_err  = 1'b0;
        case (cur_size)
            SIZE_BYTE: cur_err = 1'b0;
            SIZE_HALF: cur_err = cur_addr[0];
            SIZE_WORD: cur_err = (cur_addr[1:0] != 2'b00);
            default:   cur_err = 1'b1;
        endcase
        if (end_addr > SUM_W'(DEPTH_BYTES)) begin
            cur_err = 1'b1;
        end
    end

    // RAM controls: stores commit and loads read on the edge entering RESP.
    // rst gates both so an edge seen while reset is held touches nothing.
    always_comb begin
        enter_resp = !rst && (state_d == RESP);
        lane_we    = 4'b0000;
        ram_re     = enter_resp && !cur_we && !cur_err;
        if (enter_resp && cur_we && !cur_err) begin
            lane_we = lane_sel(cur_size, cur_addr[1:0]);
        end
        case (cur_size)
            SIZE_BYTE: lane_wdata = {4{cur_wdata[7:0]}};
            SIZE_HALF: lane_wdata = {2{cur_wdata[15:0]}};
            default:   lane_wdata = cur_wdata;
        endcase
    end

    byte_lane_ram #(
        .ROWS  (ROWS),
        .ROW_W (ROW_W)
    ) u_ram (
        .clk     (clk),
        .row_i   (cur_addr[ROW_W+1:2]),
        .we_i    (lane_we),
        .wdata_i (lane_wdata),
        .re_i    (ram_re),
        .rdata_o (ram_rdata)
    );

    // Response attributes latched alongside the RAM read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_err_q    <= 1'b0;
            rsp_zero_q   <= 1'b1;
            rsp_signed_q <= 1'b0;
            rsp_size_q   <= SIZE_BYTE;
            rsp_off_q    <= 2'b00;
        end else if (enter_resp) begin
            rsp_err_q    <= cur_err;
            rsp_zero_q   <= cur_err || cur_we;
            rsp_signed_q <= cur_signed;
            rsp_size_q   <= cur_size;
            rsp_off_q    <= cur_addr[1:0];
        end
    end

    // Lane extraction and sign/zero extension of the held read word
    always_comb begin
        case (rsp_off_q)
            2'd0:    sel_byte = ram_rdata[31:24];
            2'd1:    sel_byte = ram_rdata[23:16];
            2'd2:    sel_byte = ram_rdata[15:8];
            default: sel_byte = ram_rdata[7:0];
        endcase
        sel_half = rsp_off_q[1] ? ram_rdata[15:0] : ram_rdata[31:16];
        case (rsp_size_q)
            SIZE_BYTE: ext_data = {{24{rsp_signed_q & sel_byte[7]}}, sel_byte};
            SIZE_HALF: ext_data = {{16{rsp_signed_q & sel_half[15]}}, sel_half};
            default:   ext_data = ram_rdata;
        endcase
    end

    // Write-back register, loaded every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q <= 32'd0;
        end else begin
            wb_q <= mem_to_reg ? rsp_rdata : alu_result;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_zero_q ? 32'd0 : ext_data;
    assign rsp_err   = rsp_err_q;
    assign wb_data   = wb_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench: instance A (ADDR_W=9, no wait states) runs directed and random
// accesses against a byte-array model; instance B (WAIT_CYCLES=3) covers
// wait-state timing, back-to-back handshake and reset during WAIT.
module tb_data_memory_ctrl;

    localparam int DEPTH = 256;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_R = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_result;
    logic        mem_to_reg;

    logic        a_req_valid, a_req_ready, a_req_we, a_req_signed;
    logic [1:0]  a_req_size;
    logic [8:0]  a_req_addr;
    logic [31:0] a_req_wdata, a_rsp_rdata, a_wb_data;
    logic        a_rsp_valid, a_rsp_err;

    logic        b_req_valid, b_req_ready, b_req_we, b_req_signed;
    logic [1:0]  b_req_size;
    logic [7:0]  b_req_addr;
    logic [31:0] b_req_wdata, b_rsp_rdata, b_wb_data;
    logic        b_rsp_valid, b_rsp_err;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    logic [7:0] mem_a [DEPTH];

    always #5 clk = ~clk;

    data_memory_ctrl #(.ADDR_W(9), .DEPTH_BYTES(256), .WAIT_CYCLES(0)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_size(a_req_size), .req_signed(a_req_signed), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
        .rsp_err(a_rsp_err), .alu_result(alu_result), .mem_to_reg(mem_to_reg),
        .wb_data(a_wb_data)
    );

    data_memory_ctrl #(.ADDR_W(8), .DEPTH_BYTES(256), .WAIT_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_size(b_req_size), .req_signed(b_req_signed), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err), .alu_result(alu_result), .mem_to_reg(mem_to_reg),
        .wb_data(b_wb_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (byte array, big-endian) ----------------
    function automatic int nbytes(input logic [1:0] s);
        case (s)
            SZ_B:    return 1;
            SZ_H:    return 2;
            SZ_W:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit model_err(input logic [1:0] s, input int addr);
        if (s == SZ_R) return 1'b1;
        if (addr % nbytes(s) != 0) return 1'b1;
        if (addr + nbytes(s) > DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] s, input bit sgn, input int addr);
        logic [31:0] v;
        int n;
        v = 32'd0;
        n = nbytes(s);
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(mem_a[addr + i]);
        if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic model_store(input logic [1:0] s, input int addr, input logic [31:0] d);
        int n;
        n = nbytes(s);
        for (int i = 0; i < n; i++) mem_a[addr + i] = d[8*(n-1-i) +: 8];
    endtask

    // ---------------- one access on instance A ----------------
    task automatic access_a(input string tag, input bit we, input logic [1:0] s, input bit sgn,
                            input int addr, input logic [31:0] wd);
        logic [31:0] exp_rd, alu, got_rd;
        bit          exp_err, m2r, got_err;
        int          lat;
        exp_err = model_err(s, addr);
        exp_rd  = (we || exp_err) ? 32'd0 : model_load(s, sgn, addr);
        m2r     = 1'($urandom_range(0, 1));
        alu     = $urandom;
        @(negedge clk);
        a_req_valid  = 1'b1;
        a_req_we     = we;
        a_req_size   = s;
        a_req_signed = sgn;
        a_req_addr   = 9'(addr);
        a_req_wdata  = wd;
        mem_to_reg   = m2r;
        alu_result   = alu;
        chk({tag, "_ready"}, 32'(a_req_ready), 32'd1);
        @(posedge clk);
        #1;
        a_req_valid  = 1'b0;
        a_req_we     = ~we;
        a_req_size   = 2'($urandom);
        a_req_signed = ~sgn;
        a_req_addr   = 9'($urandom);
        a_req_wdata  = $urandom;
        if (we && !exp_err) model_store(s, addr, wd);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!a_rsp_valid && lat < 20);
        got_rd  = a_rsp_rdata;
        got_err = a_rsp_err;
        chk({tag, "_lat"}, 32'(lat), 32'd1);
        chk({tag, "_rdata"}, got_rd, exp_rd);
        chk({tag, "_err"}, 32'(got_err), 32'(exp_err));
        @(negedge clk);
        chk({tag, "_valid_pulse"}, 32'(a_rsp_valid), 32'd0);
        chk({tag, "_rdata_hold"}, a_rsp_rdata, exp_rd);
        chk({tag, "_wb"}, a_wb_data, m2r ? exp_rd : alu);
        $display("A %s we=%0d size=%0d sgn=%0d addr=0x%03h wd=0x%08h -> rdata=0x%08h err=%0d lat=%0d",
                 tag, we, s, sgn, addr, wd, got_rd, got_err, lat);
    endtask

    // ---------------- one access on instance B (WAIT_CYCLES=3) ----------------
    task automatic access_b(input string tag, input bit we, input logic [1:0] s, input logic [7:0] addr,
                            input logic [31:0] wd, input logic [31:0] exp_rd);
        int lat;
        @(negedge clk);
        b_req_valid  = 1'b1;
        b_req_we     = we;
        b_req_size   = s;
        b_req_signed = 1'b0;
        b_req_addr   = addr;
        b_req_wdata  = wd;
        mem_to_reg   = 1'b1;
        chk({tag, "_ready"}, 32'(b_req_ready), 32'd1);
        @(posedge clk);
        #1;
        b_req_valid = 1'b0;
        b_req_addr  = ~addr;
        b_req_wdata = ~wd;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!b_rsp_valid && lat < 20);
        chk({tag, "_lat"}, 32'(lat), 32'd4);
        chk({tag, "_rdata"}, b_rsp_rdata, exp_rd);
        chk({tag, "_err"}, 32'(b_rsp_err), 32'd0);
        @(negedge clk);
        chk({tag, "_wb"}, b_wb_data, exp_rd);
        $display("B %s we=%0d addr=0x%02h -> rdata=0x%08h lat=%0d", tag, we, addr, b_rsp_rdata, lat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          addr, r;
        logic [1:0]  s;
        bit          we, sgn;
        logic [31:0] alu;

        rst = 1'b1;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_size = SZ_B; a_req_signed = 1'b0;
        a_req_addr = '0; a_req_wdata = 32'd0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_size = SZ_B; b_req_signed = 1'b0;
        b_req_addr = '0; b_req_wdata = 32'd0;
        alu_result = 32'd0; mem_to_reg = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem_a[i] = 8'h00;

        // reset state
        @(negedge clk);
        chk("rst_a_ready", 32'(a_req_ready), 32'd1);
        chk("rst_a_valid", 32'(a_rsp_valid), 32'd0);
        chk("rst_a_rdata", a_rsp_rdata, 32'd0);
        chk("rst_a_err", 32'(a_rsp_err), 32'd0);
        chk("rst_a_wb", a_wb_data, 32'd0);
        chk("rst_b_ready", 32'(b_req_ready), 32'd1);
        chk("rst_b_valid", 32'(b_rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // clear instance A so the model and RAM start identical
        for (int i = 0; i < DEPTH / 4; i++) access_a($sformatf("clr%0d", i), 1'b1, SZ_W, 1'b0, 4 * i, 32'd0);

        // word store/load and lane reads
        access_a("t1_st_w10", 1'b1, SZ_W, 1'b0, 'h10, 32'hDEADBEEF);
        access_a("t1_ld_w10", 1'b0, SZ_W, 1'b0, 'h10, 32'd0);
        access_a("t2_ld_b11s", 1'b0, SZ_B, 1'b1, 'h11, 32'd0);
        access_a("t2_ld_b11u", 1'b0, SZ_B, 1'b0, 'h11, 32'd0);
        access_a("t2_ld_h12s", 1'b0, SZ_H, 1'b1, 'h12, 32'd0);
        access_a("t2_ld_h12u", 1'b0, SZ_H, 1'b0, 'h12, 32'd0);
        access_a("t3_st_b13", 1'b1, SZ_B, 1'b0, 'h13, 32'h0000005A);
        access_a("t3_ld_w10", 1'b0, SZ_W, 1'b0, 'h10, 32'd0);
        // errors and range boundary
        access_a("t4_ld_w12", 1'b0, SZ_W, 1'b0, 'h12, 32'd0);
        access_a("t4_st_h01", 1'b1, SZ_H, 1'b0, 'h01, 32'h0000ABCD);
        access_a("t4_ld_w00", 1'b0, SZ_W, 1'b0, 'h00, 32'd0);
        access_a("t4_st_wfc", 1'b1, SZ_W, 1'b0, 'hFC, 32'h80FF7F01);
        access_a("t4_ld_wfc", 1'b0, SZ_W, 1'b0, 'hFC, 32'd0);
        access_a("t4_ld_bff", 1'b0, SZ_B, 1'b1, 'hFF, 32'd0);
        access_a("t4_ld_w100", 1'b0, SZ_W, 1'b0, 'h100, 32'd0);
        access_a("t4_st_b100", 1'b1, SZ_B, 1'b0, 'h100, 32'h000000EE);
        access_a("t4_ld_hfe", 1'b0, SZ_H, 1'b1, 'hFE, 32'd0);
        access_a("t4_rsvd", 1'b0, SZ_R, 1'b0, 'h20, 32'd0);

        // random traffic
        for (int n = 0; n < 150; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 3) s = SZ_B;
            else if (r < 6) s = SZ_H;
            else if (r < 9) s = SZ_W;
            else s = SZ_R;
            if ($urandom_range(0, 7) == 0) addr = int'($urandom_range(0, 511));
            else addr = int'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0 && s != SZ_R) addr = addr - (addr % nbytes(s));
            we  = 1'($urandom_range(0, 1));
            sgn = 1'($urandom_range(0, 1));
            access_a($sformatf("rnd%0d", n), we, s, sgn, addr, $urandom);
        end

        // instance B: seed a known word, then wait-state timing
        access_b("t6_init20", 1'b1, SZ_W, 8'h20, 32'h00000000, 32'd0);
        @(negedge clk);
        b_req_valid = 1'b1; b_req_we = 1'b1; b_req_size = SZ_W; b_req_addr = 8'h24;
        b_req_wdata = 32'h11223344; mem_to_reg = 1'b1;
        chk("t5_ready_T", 32'(b_req_ready), 32'd1);
        @(posedge clk);
        #1;
        b_req_we = 1'b0; b_req_wdata = 32'd0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("t5_ready_T+%0d", k), 32'(b_req_ready), 32'd0);
            chk($sformatf("t5_valid_T+%0d", k), 32'(b_rsp_valid), (k == 4) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        chk("t5_ready_T+5", 32'(b_req_ready), 32'd1);
        chk("t5_valid_T+5", 32'(b_rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        b_req_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("t5_2nd_valid_%0d", k), 32'(b_rsp_valid), (k == 4) ? 32'd1 : 32'd0);
        end
        chk("t5_2nd_rdata", b_rsp_rdata, 32'h11223344);
        chk("t5_2nd_err", 32'(b_rsp_err), 32'd0);
        $display("B t5 back-to-back store/load @0x24 -> rdata=0x%08h", b_rsp_rdata);
        @(negedge clk);
        chk("t5_wb", b_wb_data, 32'h11223344);

        // reset during WAIT of a store
        @(negedge clk);
        b_req_valid = 1'b1; b_req_we = 1'b1; b_req_size = SZ_W; b_req_addr = 8'h20;
        b_req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        b_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_b_ready", 32'(b_req_ready), 32'd1);
        chk("t6_b_valid", 32'(b_rsp_valid), 32'd0);
        chk("t6_b_rdata", b_rsp_rdata, 32'd0);
        chk("t6_b_err", 32'(b_rsp_err), 32'd0);
        chk("t6_b_wb", b_wb_data, 32'd0);
        chk("t6_a_wb", a_wb_data, 32'd0);
        $display("B t6 reset asserted during WAIT of store @0x20");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        access_b("t6_ld20", 1'b0, SZ_W, 8'h20, 32'd0, 32'd0);
        alu = $urandom;
        @(negedge clk);
        mem_to_reg = 1'b0;
        alu_result = alu;
        @(posedge clk);
        #1;
        chk("t6_wb_alu", b_wb_data, alu);
        $display("B t6 mem_to_reg=0 -> wb=0x%08h", b_wb_data);

        // instance A memory survives reset
        access_a("t6_a_ld_w10", 1'b0, SZ_W, 1'b0, 'h10, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
